// File: rtl/ram_master_port_if.sv
// ---------------------------------------------------------------------------
// ram_master_port_if
// Groups the CPU request/response handshake and the word-RAM port of
// ram_master_port into one bundle.
//   CPU side : reqValid, reqReady, reqWrite, reqSize, reqSigned, reqAddr,
//              reqWdata, respValid, respError, respRdata
//   RAM side : memRead, memWrite, memBwe, memAddress, memDataIn,
//              memReadValid, memDataOut
// modport master : the controller (drives strobes and responses)
// modport slave  : the environment (CPU data path plus RAM)
// ---------------------------------------------------------------------------
interface ram_master_port_if #(
   parameter int ADDR_WIDTH = 14
);
   logic                  reqValid;
   logic                  reqReady;
   logic                  reqWrite;
   logic [1:0]            reqSize;
   logic                  reqSigned;
   logic [ADDR_WIDTH-1:0] reqAddr;
   logic [31:0]           reqWdata;
   logic                  respValid;
   logic                  respError;
   logic [31:0]           respRdata;
   logic                  memRead;
   logic                  memWrite;
   logic [3:0]            memBwe;
   logic [ADDR_WIDTH-3:0] memAddress;
   logic [31:0]           memDataIn;
   logic                  memReadValid;
   logic [31:0]           memDataOut;

   modport master (
      input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata,
      input  memReadValid, memDataOut,
      output reqReady, respValid, respError, respRdata,
      output memRead, memWrite, memBwe, memAddress, memDataIn
   );

   modport slave (
      output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata,
      output memReadValid, memDataOut,
      input  reqReady, respValid, respError, respRdata,
      input  memRead, memWrite, memBwe, memAddress, memDataIn
   );
endinterface

// File: rtl/ram_master_port.sv
// ---------------------------------------------------------------------------
// ram_master_port
// Initiator-side controller for the on-chip word RAM. Accepts one byte,
// halfword or word load/store at a time, drives a one-cycle RAM strobe with
// byte enables and lane-replicated write data, waits for read data on loads,
// and returns a one-cycle response with extended load data or an error flag
// (misaligned, illegal size, or read timeout).
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   bus    : ram_master_port_if.master (request, response and RAM signals)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ram_master_port #(
   parameter int ADDR_WIDTH = 14,
   parameter int TIMEOUT    = 15
) (
   input  logic                clk,
   input  logic                reset,
   ram_master_port_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

   // True for size 3 and for half/word requests that are not naturally aligned.
   function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offs);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = offs[0];
         2'd2:    bad = (offs != 2'd0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] offs);
      logic [3:0] bwe;
      case (size)
         2'd0:    bwe = 4'b0001 << offs;
         2'd1:    bwe = 4'b0011 << {offs[1], 1'b0};
         default: bwe = 4'b1111;
      endcase
      return bwe;
   endfunction

   // Store data is replicated across lanes so the byte enables alone select it.
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         2'd0:    d = {4{wdata[7:0]}};
         2'd1:    d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] extract_load(input logic [31:0] data, input logic [1:0] offs,
                                                input logic [1:0] size, input logic sgn);
      logic [31:0] sh;
      logic [31:0] r;
      sh = data >> {offs, 3'b000};
      case (size)
         2'd0:    r = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'd0, sh[7:0]};
         2'd1:    r = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   state_t      state_r, state_s;
   logic [3:0]  cnt_r, cnt_s, cnt_inc_s;
   logic        hs_s;
   logic        resp_err_s;
   logic [31:0] resp_data_s;

   logic        wr_r;
   logic [1:0]  size_r;
   logic        sgn_r;
   logic [1:0]  offs_r;

   logic                  ready_r;
   logic                  resp_valid_r;
   logic                  resp_err_r;
   logic [31:0]           resp_rdata_r;
   logic                  mem_read_r;
   logic                  mem_write_r;
   logic [3:0]            mem_bwe_r;
   logic [ADDR_WIDTH-3:0] mem_addr_r;
   logic [31:0]           mem_din_r;

   assign hs_s      = (state_r == IDLE) & bus.reqValid;
   assign cnt_inc_s = cnt_r + 4'd1;

   // Next-state, timeout counter and next response values.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      resp_err_s  = 1'b0;
      resp_data_s = 32'd0;
      case (state_r)
         IDLE: begin
            if (hs_s) begin
               if (is_bad_access(bus.reqSize, bus.reqAddr[1:0])) begin
                  state_s    = RESP;
                  resp_err_s = 1'b1;
               end else begin
                  state_s = ISSUE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            cnt_s = 4'd0;
            if (wr_r) begin
               state_s = RESP;
            end else begin
               state_s = WAIT;
            end
         end
         WAIT: begin
            if (bus.memReadValid) begin
               state_s     = RESP;
               resp_data_s = extract_load(bus.memDataOut, offs_r, size_r, sgn_r);
            end else if (cnt_inc_s == TIMEOUT_C) begin
               state_s    = RESP;
               resp_err_s = 1'b1;
            end else begin
               cnt_s = cnt_inc_s;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and timeout counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Request fields needed after the handshake (write flag and load extraction).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_r   <= 1'b0;
         size_r <= 2'd0;
         sgn_r  <= 1'b0;
         offs_r <= 2'd0;
      end else if (hs_s) begin
         wr_r   <= bus.reqWrite;
         size_r <= bus.reqSize;
         sgn_r  <= bus.reqSigned;
         offs_r <= bus.reqAddr[1:0];
      end
   end

   // RAM port outputs: strobes pulse for the ISSUE cycle, the rest hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_bwe_r   <= 4'd0;
         mem_addr_r  <= '0;
         mem_din_r   <= 32'd0;
      end else if ((state_r == IDLE) && (state_s == ISSUE)) begin
         mem_read_r  <= ~bus.reqWrite;
         mem_write_r <= bus.reqWrite;
         mem_bwe_r   <= lane_enables(bus.reqSize, bus.reqAddr[1:0]);
         mem_addr_r  <= bus.reqAddr[ADDR_WIDTH-1:2];
         mem_din_r   <= lane_data(bus.reqSize, bus.reqWdata);
      end else begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
      end
   end

   // Handshake and response outputs, valid only for the RESP cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_r      <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'd0;
      end else begin
         ready_r      <= (state_s == IDLE);
         resp_valid_r <= (state_s == RESP);
         resp_err_r   <= resp_err_s;
         resp_rdata_r <= resp_data_s;
      end
   end

   assign bus.reqReady   = ready_r;
   assign bus.respValid  = resp_valid_r;
   assign bus.respError  = resp_err_r;
   assign bus.respRdata  = resp_rdata_r;
   assign bus.memRead    = mem_read_r;
   assign bus.memWrite   = mem_write_r;
   assign bus.memBwe     = mem_bwe_r;
   assign bus.memAddress = mem_addr_r;
   assign bus.memDataIn  = mem_din_r;

endmodule

// File: tb/tb_ram_master_port.sv
// ---------------------------------------------------------------------------
// tb_ram_master_port
// Self-checking bench for ram_master_port. A clocked RAM model answers reads
// with readValid two cycles after the strobe. Expected results come from a
// byte-addressed reference memory and the access rules written as plain
// arithmetic.
// ---------------------------------------------------------------------------
module tb_ram_master_port;

   localparam int AW      = 14;
   localparam int TIMEOUT = 15;

   logic clk;
   logic reset;

   ram_master_port_if #(.ADDR_WIDTH(AW)) bus ();

   ram_master_port #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // RAM model
   logic [31:0] ram [0:(1<<(AW-2))-1];
   logic        ram_respond;
   logic        stray_rv;
   logic        rv_d1;
   logic [31:0] rd_d1;

   // Reference memory
   logic [7:0] ref_mem [0:(1<<AW)-1];

   initial begin
      for (int i = 0; i < (1 << (AW-2)); i++) ram[i] = 32'd0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'd0;
   end

   // Clocked RAM: byte-enabled writes, reads return two cycles after the strobe.
   always @(posedge clk) begin
      if (bus.memWrite) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.memBwe[b]) ram[bus.memAddress][8*b +: 8] <= bus.memDataIn[8*b +: 8];
         end
      end
      rv_d1            <= bus.memRead & ram_respond;
      rd_d1            <= ram[bus.memAddress];
      bus.memReadValid <= rv_d1 | stray_rv;
      bus.memDataOut   <= rd_d1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request and compare everything it produces against the rules.
   task automatic run_req(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [AW-1:0] a, input logic [31:0] wd, input bit respond);
      int          n;
      bit          bad;
      int          nrd, nwr, strobe_cyc, resp_cyc;
      logic        ready_t1, err;
      logic [31:0] rdata, s_bwe, s_addr, s_din;
      logic [31:0] e_bwe, e_din, e_rdata, e_cyc;
      longint      v;

      ram_respond = respond;
      @(negedge clk);
      bus.reqValid  = 1'b1;
      bus.reqWrite  = wr;
      bus.reqSize   = sz;
      bus.reqSigned = sg;
      bus.reqAddr   = a;
      bus.reqWdata  = wd;
      @(posedge clk);
      nrd = 0; nwr = 0; strobe_cyc = -1; resp_cyc = -1;
      ready_t1 = 1'b1; err = 1'b0; rdata = 32'd0;
      s_bwe = 32'd0; s_addr = 32'd0; s_din = 32'd0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            bus.reqValid = 1'b0;
            ready_t1     = bus.reqReady;
         end
         if (bus.memRead || bus.memWrite) begin
            strobe_cyc = cyc;
            s_bwe      = {28'd0, bus.memBwe};
            s_addr     = 32'(bus.memAddress);
            s_din      = bus.memDataIn;
         end
         if (bus.memRead)  nrd++;
         if (bus.memWrite) nwr++;
         if (bus.respValid) begin
            resp_cyc = cyc;
            err      = bus.respError;
            rdata    = bus.respRdata;
            break;
         end
      end

      n   = (sz == 2'd3) ? 0 : (1 << sz);
      bad = (sz == 2'd3) || ((int'(a) % n) != 0);
      if (bad)        e_cyc = 32'd1;
      else if (wr)    e_cyc = 32'd2;
      else if (respond) e_cyc = 32'd4;
      else            e_cyc = 32'(2 + TIMEOUT);

      e_rdata = 32'd0;
      if (!bad && !wr && respond) begin
         v = 0;
         for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
         if (sg && (((v >> (8 * n - 1)) & 64'd1) != 0)) v = v - (longint'(1) << (8 * n));
         e_rdata = v[31:0];
      end

      check_val("resp_cycle", 32'(resp_cyc), e_cyc);
      check_val("resp_error", {31'd0, err}, {31'd0, bad || (!wr && !respond)});
      check_val("resp_rdata", rdata, e_rdata);
      check_val("ready_busy", {31'd0, ready_t1}, 32'd0);
      check_val("read_strobes", 32'(nrd), 32'((!bad && !wr) ? 1 : 0));
      check_val("write_strobes", 32'(nwr), 32'((!bad && wr) ? 1 : 0));

      if (!bad) begin
         e_bwe = 32'd0;
         e_din = 32'd0;
         for (int i = 0; i < 4; i++) begin
            if (i >= (int'(a) % 4) && i < (int'(a) % 4) + n) e_bwe[i] = 1'b1;
            e_din[8*i +: 8] = wd[8*(i % n) +: 8];
         end
         check_val("strobe_cycle", 32'(strobe_cyc), 32'd1);
         check_val("mem_address", s_addr, 32'(a) >> 2);
         check_val("mem_bwe", s_bwe, e_bwe);
         if (wr) begin
            check_val("mem_datain", s_din, e_din);
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
         end
      end

      @(negedge clk);
      check_val("resp_pulse_end", {31'd0, bus.respValid}, 32'd0);
      check_val("ready_after", {31'd0, bus.reqReady}, 32'd1);
   endtask

   initial begin
      int resp_cnt;
      bit          r_wr, r_sg;
      logic [1:0]  r_sz;
      logic [AW-1:0] r_a;

      reset            = 1'b1;
      ram_respond      = 1'b1;
      stray_rv         = 1'b0;
      bus.reqValid     = 1'b0;
      bus.reqWrite     = 1'b0;
      bus.reqSize      = 2'd0;
      bus.reqSigned    = 1'b0;
      bus.reqAddr      = '0;
      bus.reqWdata     = 32'd0;

      repeat (3) @(negedge clk);
      check_val("rst_ready", {31'd0, bus.reqReady}, 32'd1);
      check_val("rst_resp_valid", {31'd0, bus.respValid}, 32'd0);
      check_val("rst_mem_strobes", {30'd0, bus.memRead, bus.memWrite}, 32'd0);
      check_val("rst_mem_bwe", {28'd0, bus.memBwe}, 32'd0);
      check_val("rst_mem_datain", bus.memDataIn, 32'd0);
      reset = 1'b0;

      // Directed sequence from the test plan.
      run_req(1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 1'b1);
      run_req(1'b1, 2'd0, 1'b0, 14'h013, 32'h000000A5, 1'b1);
      run_req(1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 1'b1);
      run_req(1'b1, 2'd2, 1'b0, 14'h010, 32'h80FF7F01, 1'b1);
      run_req(1'b0, 2'd0, 1'b1, 14'h013, 32'h0, 1'b1);
      run_req(1'b0, 2'd0, 1'b0, 14'h013, 32'h0, 1'b1);
      run_req(1'b0, 2'd1, 1'b1, 14'h012, 32'h0, 1'b1);
      run_req(1'b0, 2'd1, 1'b0, 14'h011, 32'h0, 1'b1);
      run_req(1'b1, 2'd2, 1'b0, 14'h002, 32'h12345678, 1'b1);
      run_req(1'b0, 2'd3, 1'b0, 14'h000, 32'h0, 1'b1);

      // Read that never completes, then a stray readValid while idle.
      run_req(1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 1'b0);
      stray_rv = 1'b1;
      @(negedge clk);
      stray_rv = 1'b0;
      resp_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.respValid) resp_cnt++;
      end
      check_val("stray_rv_resp", 32'(resp_cnt), 32'd0);
      check_val("stray_rv_ready", {31'd0, bus.reqReady}, 32'd1);

      // Reset while waiting for read data.
      ram_respond = 1'b0;
      @(negedge clk);
      bus.reqValid = 1'b1;
      bus.reqWrite = 1'b0;
      bus.reqSize  = 2'd2;
      bus.reqAddr  = 14'h020;
      @(posedge clk);
      @(negedge clk);
      bus.reqValid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("abort_ready", {31'd0, bus.reqReady}, 32'd1);
      check_val("abort_strobes", {30'd0, bus.memRead, bus.memWrite}, 32'd0);
      check_val("abort_resp", {31'd0, bus.respValid}, 32'd0);
      check_val("abort_addr_bwe", {bus.memAddress, 4'd0, bus.memBwe}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      resp_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.respValid) resp_cnt++;
      end
      check_val("abort_no_resp", 32'(resp_cnt), 32'd0);
      run_req(1'b1, 2'd1, 1'b0, 14'h022, 32'h0000CAFE, 1'b1);
      run_req(1'b0, 2'd1, 1'b1, 14'h022, 32'h0, 1'b1);

      // Randomized traffic over a small window so loads hit earlier stores.
      for (int k = 0; k < 60; k++) begin
         r_wr = 1'($urandom_range(0, 1));
         r_sg = 1'($urandom_range(0, 1));
         r_sz = 2'($urandom_range(0, 3));
         r_a  = AW'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0 && r_sz != 2'd3) r_a = r_a & ~(AW'((1 << r_sz) - 1));
         run_req(r_wr, r_sz, r_sg, r_a, $urandom, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
